// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and the seven-segment decoders that consume its digits.
package bin2bcd_pkg;

  localparam int DIGIT_W     = 4;
  localparam int ADD3_THRESH = 5;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Digits never exceed 12 after correction, so 4-bit wraparound cannot occur.
  assign adjusted = (digit >= bcd_digit_t'(ADD3_THRESH)) ? digit + bcd_digit_t'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking mask enabled by defining BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [4*DIGITS-1:0]       bcd,
  output logic                      overflow
`ifdef BIN2BCD_LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]         lz_mask
`endif
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t            state;
  logic [SH_W-1:0]   shift_reg;
  logic [SH_W-1:0]   adjusted;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [BCD_W-1:0]  result;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .digit    (shift_reg[BIN_W + gi*DIGIT_W +: DIGIT_W]),
        .adjusted (adjusted [BIN_W + gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign adjusted[BIN_W-1:0] = shift_reg[BIN_W-1:0];
  assign result = ovf ? ALL_NINES : shift_reg[SH_W-1 -: BCD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= {{BCD_W{1'b0}}, bin};
            ovf       <= 1'b0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          // A bit leaving the top digit means the value needs more digits than we have.
          shift_reg <= {adjusted[SH_W-2:0], 1'b0};
          if (adjusted[SH_W-1]) ovf <= 1'b1;
          count <= count + 1'b1;
          if (count == CNT_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          bcd      <= result;
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);
  logic [DIGITS-1:0] lz_next;

  // Digit 0 is never blanked so that zero still shows a single "0".
  assign lz_next[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz_next[gi] = (result[BCD_W-1 : gi*DIGIT_W] == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_mask <= LZ_RST;
    end else if (state == DONE) begin
      lz_mask <= lz_next;
    end
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: decimal-arithmetic reference model,
// per-cycle output comparison, plus literal checks. Covers BIN2BCD_LZ_BLANK_EN when defined.
module tb_bin2bcd_seq;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [9:0]  bin_a = '0;
  logic [13:0] bin_b = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] bcd_a, bcd_b;
`ifdef BIN2BCD_LZ_BLANK_EN
  logic [3:0]  lz_a, lz_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(10), .DIGITS(D)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
`ifdef BIN2BCD_LZ_BLANK_EN
    , .lz_mask(lz_a)
`endif
  );

  bin2bcd_seq #(.BIN_W(14), .DIGITS(D)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
`ifdef BIN2BCD_LZ_BLANK_EN
    , .lz_mask(lz_b)
`endif
  );

  // Reference: plain decimal arithmetic with saturation at 10^D-1.
  function automatic void ref_conv(input longint unsigned v, output logic [15:0] b, output logic o);
    b = '0;
    o = (v > 9999);
    if (o) b = 16'h9999;
    else for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  function automatic logic [3:0] ref_lz(input longint unsigned v);
    longint unsigned n = (v > 9999) ? 9999 : v;
    logic [3:0] m = 4'b0000;
    longint unsigned p = 10;
    for (int i = 1; i < D; i++) begin
      m[i] = (n < p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: index 0 = 10-bit instance, 1 = 14-bit instance.
  int              cnt[2]      = '{0, 0};
  longint unsigned pend[2]     = '{0, 0};
  logic            exp_busy[2] = '{0, 0};
  logic            exp_done[2] = '{0, 0};
  logic            exp_ovf[2]  = '{0, 0};
  logic [15:0]     exp_bcd[2]  = '{16'h0, 16'h0};
  logic [3:0]      exp_lz[2]   = '{4'b1110, 4'b1110};

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cnt[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
        exp_bcd[k] = '0; exp_ovf[k] = 0; exp_lz[k] = 4'b1110;
      end else begin
        exp_done[k] = 0;
        if (cnt[k] == 0) begin
          if ((k == 0) ? start_a : start_b) begin
            pend[k] = (k == 0) ? longint'(bin_a) : longint'(bin_b);
            cnt[k] = ((k == 0) ? 10 : 14) + 1;
            exp_busy[k] = 1;
          end
        end else begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            exp_busy[k] = 0;
            exp_done[k] = 1;
            ref_conv(pend[k], exp_bcd[k], exp_ovf[k]);
            exp_lz[k] = ref_lz(pend[k]);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy_a", 32'(busy_a), 32'(exp_busy[0]));
    chk("done_a", 32'(done_a), 32'(exp_done[0]));
    chk("bcd_a",  32'(bcd_a),  32'(exp_bcd[0]));
    chk("ovf_a",  32'(ovf_a),  32'(exp_ovf[0]));
    chk("busy_b", 32'(busy_b), 32'(exp_busy[1]));
    chk("done_b", 32'(done_b), 32'(exp_done[1]));
    chk("bcd_b",  32'(bcd_b),  32'(exp_bcd[1]));
    chk("ovf_b",  32'(ovf_b),  32'(exp_ovf[1]));
`ifdef BIN2BCD_LZ_BLANK_EN
    chk("lz_a", 32'(lz_a), 32'(exp_lz[0]));
    chk("lz_b", 32'(lz_b), 32'(exp_lz[1]));
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One conversion on instance k; checks latency and prints one line.
  task automatic conv(input int k, input longint unsigned v);
    int lat = 0;
    int bw = (k == 0) ? 10 : 14;
    if (k == 0) begin start_a = 1'b1; bin_a = 10'(v); end
    else        begin start_b = 1'b1; bin_b = 14'(v); end
    step();
    start_a = 1'b0; start_b = 1'b0;
    bin_a = 10'($urandom); bin_b = 14'($urandom);
    for (int i = 1; i <= 25; i++) begin
      step();
      if ((k == 0) ? done_a : done_b) begin lat = i; break; end
    end
    chk($sformatf("latency%0d_%0d", k, v), 32'(lat), 32'(bw + 1));
    $display("conv%0d bin=%0d bcd=%h ovf=%b lat=%0d", k, v,
             (k == 0) ? bcd_a : bcd_b, (k == 0) ? ovf_a : ovf_b, lat);
    step();
  endtask

  initial begin
    logic [15:0] mb;
    logic        mo;
    int          ndone;

    ref_conv(1023, mb, mo);  chk("model_1023", 32'({mo, mb}), 32'({1'b0, 16'h1023}));
    ref_conv(12345, mb, mo); chk("model_12345", 32'({mo, mb}), 32'({1'b1, 16'h9999}));
    chk("model_lz_42", 32'(ref_lz(42)), 32'(4'b1100));

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_bcd_a", 32'(bcd_a), 32'h0);
    chk("reset_busy_a", 32'(busy_a), 32'h0);
    step();

    conv(0, 0);    chk("lit_0",    32'(bcd_a), 32'h0000);
    conv(0, 1023); chk("lit_1023", 32'(bcd_a), 32'h1023);
    conv(0, 7);    chk("lit_7",    32'(bcd_a), 32'h0007);
    conv(0, 999);  chk("lit_999",  32'(bcd_a), 32'h0999);

    // Reset in the middle of a conversion of 512.
    start_a = 1'b1; bin_a = 10'd512;
    step();
    start_a = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_bcd", 32'(bcd_a), 32'h0);
    chk("midreset_busy", 32'(busy_a), 32'h0);
    step(); step();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done_a) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'h0);
    conv(0, 512); chk("lit_512", 32'(bcd_a), 32'h0512);

    // Start held high with bin changing every cycle.
    start_a = 1'b1;
    for (int i = 0; i < 48; i++) begin
      bin_a = 10'($urandom);
      step();
    end
    start_a = 1'b0;
    repeat (14) step();

    for (int i = 0; i < 16; i++) conv(0, $urandom_range(0, 1023));

    conv(1, 12345); chk("lit_12345", 32'({ovf_b, bcd_b}), 32'({1'b1, 16'h9999}));
    conv(1, 9999);  chk("lit_9999",  32'({ovf_b, bcd_b}), 32'({1'b0, 16'h9999}));
    conv(1, 10000); chk("lit_10000", 32'({ovf_b, bcd_b}), 32'({1'b1, 16'h9999}));
    for (int i = 0; i < 8; i++) conv(1, $urandom_range(0, 16383));

`ifdef BIN2BCD_LZ_BLANK_EN
    conv(0, 42);   chk("lz_42",   32'(lz_a), 32'(4'b1100));
    conv(0, 0);    chk("lz_0",    32'(lz_a), 32'(4'b1110));
    conv(0, 1000); chk("lz_1000", 32'(lz_a), 32'(4'b0000));
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
